regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Two-port write arbiter in front of an 8x16 register file write port.
//   After reset it first clears registers 0..NREG-1 (INIT), then grants one
//   writer per cycle (RUN). Port 0 is the ALU writeback and port 1 is the
//   memory load. Ties are broken by a round-robin priority pointer.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset
//   req0/wa0/wd0 : port 0 write request, address, data
//   req1/wa1/wd1 : port 1 write request, address, data
//   gnt0/gnt1  : one-cycle grant pulse per port (registered)
//   we3/wa3/wd3: register file write enable, address, data (registered)
//   init_busy  : high while the clear sequence runs
module regfile_wr_arbiter #(
  parameter int NREG   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [2:0]        wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              req1,
  input  logic [2:0]        wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              we3,
  output logic [2:0]        wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              init_busy
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] LAST = 3'(NREG - 1);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              prio, prio_nxt;   // 0: port 0 wins a tie, 1: port 1 wins
  logic              elig0, elig1, sel1, grant;
  logic              we_nxt, gnt0_nxt, gnt1_nxt;
  logic [2:0]        wa_nxt;
  logic [DATA_W-1:0] wd_nxt;

  // A port that holds a grant this cycle is being consumed, so it cannot be
  // granted again at the edge that ends this cycle.
  assign elig0 = req0 & ~gnt0;
  assign elig1 = req1 & ~gnt1;
  assign sel1  = elig1 & (~elig0 | prio);
  assign grant = elig0 | elig1;

  assign init_busy = (state == INIT);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= 3'd0;
      prio  <= 1'b0;
      we3   <= 1'b0;
      wa3   <= 3'd0;
      wd3   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prio  <= prio_nxt;
      we3   <= we_nxt;
      wa3   <= wa_nxt;
      wd3   <= wd_nxt;
      gnt0  <= gnt0_nxt;
      gnt1  <= gnt1_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prio_nxt  = prio;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        // The pointer moves to whichever port was not just served.
        if (grant) prio_nxt = ~sel1;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Output logic: values loaded into the output registers at the next edge
  always_comb begin
    we_nxt   = 1'b0;
    wa_nxt   = 3'd0;
    wd_nxt   = '0;
    gnt0_nxt = 1'b0;
    gnt1_nxt = 1'b0;
    case (state)
      INIT: begin
        we_nxt = 1'b1;
        wa_nxt = cnt;
      end
      RUN: begin
        if (grant) begin
          we_nxt = 1'b1;
          if (sel1) begin
            gnt1_nxt = 1'b1;
            wa_nxt   = wa1;
            wd_nxt   = wd1;
          end else begin
            gnt0_nxt = 1'b1;
            wa_nxt   = wa0;
            wd_nxt   = wd0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int NREG = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  wa0, wa1;
  logic [15:0] wd0, wd1;
  logic        gnt0, gnt1, we3, init_busy;
  logic [2:0]  wa3;
  logic [15:0] wd3;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.NREG(NREG), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wa0(wa0), .wd0(wd0),
    .req1(req1), .wa1(wa1), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the write port must show in each cycle.
  bit        m_valid = 0;
  bit        m_init;
  int        m_clear_idx;
  int        m_last;        // port that got the last tie-relevant grant: 0/1
  bit        m_we, m_g0, m_g1;
  int        m_wa, m_wd;

  always @(posedge clk) begin
    bit want0, want1;
    int winner;
    if (reset === 1'b1) begin
      m_valid = 1; m_init = 1; m_clear_idx = 0; m_last = 1;
      m_we = 0; m_g0 = 0; m_g1 = 0; m_wa = 0; m_wd = 0;
    end else if (m_valid) begin
      if (m_init) begin
        m_we = 1; m_g0 = 0; m_g1 = 0; m_wa = m_clear_idx; m_wd = 0;
        m_clear_idx++;
        if (m_clear_idx == NREG) m_init = 0;
      end else begin
        want0 = req0 && !m_g0;
        want1 = req1 && !m_g1;
        winner = -1;
        if (want0 && want1) winner = (m_last == 0) ? 1 : 0;
        else if (want0) winner = 0;
        else if (want1) winner = 1;
        m_g0 = (winner == 0);
        m_g1 = (winner == 1);
        m_we = (winner >= 0);
        m_wa = (winner == 0) ? int'(wa0) : (winner == 1) ? int'(wa1) : 0;
        m_wd = (winner == 0) ? int'(wd0) : (winner == 1) ? int'(wd1) : 0;
        if (winner >= 0) m_last = winner;
      end
    end
  end

  // Register file image fed by the DUT write port.
  logic [15:0] rf [0:7];
  always @(posedge clk) if (we3 === 1'b1) rf[wa3] <= wd3;

  // Per-cycle comparison against the model, plus invariants.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_we3", {31'd0, we3}, {31'd0, m_we});
      chk("m_wa3", {29'd0, wa3}, 32'(m_wa));
      chk("m_wd3", {16'd0, wd3}, 32'(m_wd));
      chk("m_gnt0", {31'd0, gnt0}, {31'd0, m_g0});
      chk("m_gnt1", {31'd0, gnt1}, {31'd0, m_g1});
      chk("m_init_busy", {31'd0, init_busy}, {31'd0, m_init});
      chk("inv_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("inv_gnt_we", {31'd0, (gnt0 | gnt1) & ~we3}, 32'd0);
      chk("inv_busy_gnt", {31'd0, init_busy & (gnt0 | gnt1)}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic e_we, input logic [2:0] e_wa,
                            input logic [15:0] e_wd, input logic e_g0, input logic e_g1,
                            input logic e_busy);
    chk({name, "_we3"}, {31'd0, we3}, {31'd0, e_we});
    chk({name, "_wa3"}, {29'd0, wa3}, {29'd0, e_wa});
    chk({name, "_wd3"}, {16'd0, wd3}, {16'd0, e_wd});
    chk({name, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, e_g1, e_g0});
    chk({name, "_busy"}, {31'd0, init_busy}, {31'd0, e_busy});
  endtask

  task automatic run_clear();
    reset = 0;
    for (int i = 0; i < NREG; i++) begin
      step();
      expect_out("clr", 1'b1, 3'(i), 16'h0000, 1'b0, 1'b0, (i < NREG - 1));
    end
  endtask

  initial begin
    reset = 1; req0 = 0; req1 = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;

    // Reset state, then the eight-write clear sequence.
    step();
    expect_out("rst", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_clear();
    step();
    expect_out("idle0", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Single requester: grant, consumed cycle, regrant.
    req0 = 1; wa0 = 3'd3; wd0 = 16'hA5A5;
    step(); expect_out("p0_g", 1'b1, 3'd3, 16'hA5A5, 1'b1, 1'b0, 1'b0);
    step(); expect_out("p0_cons", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(); expect_out("p0_regr", 1'b1, 3'd3, 16'hA5A5, 1'b1, 1'b0, 1'b0);
    req0 = 0;
    step(); expect_out("idle1", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Fresh reset so the pointer favours port 0, then a simultaneous pair.
    reset = 1;
    step(); expect_out("rst2", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_clear();
    req0 = 1; wa0 = 3'd1; wd0 = 16'h1111;
    req1 = 1; wa1 = 3'd2; wd1 = 16'h2222;
    step(); expect_out("tie_g0", 1'b1, 3'd1, 16'h1111, 1'b1, 1'b0, 1'b0);
    req0 = 0;
    step(); expect_out("tie_g1", 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b0);
    req1 = 0;
    step(); expect_out("idle2", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Both held on the same address: grants alternate, last one wins.
    req0 = 1; wa0 = 3'd5; wd0 = 16'h0001;
    req1 = 1; wa1 = 3'd5; wd1 = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out("alt", 1'b1, 3'd5, (k % 2 == 1) ? 16'h0002 : 16'h0001,
                 (k % 2 == 0), (k % 2 == 1), 1'b0);
    end
    req0 = 0; req1 = 0;
    step(); expect_out("idle3", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("r5_last", {16'd0, rf[5]}, 32'h0000_0002);

    // Reset in the middle of the clear restarts it at register 0.
    reset = 1;
    step(); expect_out("rst3", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("clr_part", 1'b1, 3'(i), 16'h0000, 1'b0, 1'b0, 1'b1);
    end
    reset = 1;
    step(); expect_out("rst_mid", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_clear();

    // Request dropped by reset, then served after the new clear.
    req1 = 1; wa1 = 3'd6; wd1 = 16'hBEEF;
    reset = 1;
    step(); expect_out("rst_req", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_clear();
    step(); expect_out("p1_after", 1'b1, 3'd6, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    req1 = 0;
    step(); expect_out("idle4", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
